// File: rtl/prga_enc.sv
// ARC4 encryption engine: PRGA over an initialised S memory, PT -> CT with length prefix.
// Optional RC4-drop[DROP_N] keystream discard phase enabled by defining PRGA_ENC_DROP_EN.
module prga_enc
`ifdef PRGA_ENC_DROP_EN
#(
    parameter int unsigned DROP_N = 256
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    localparam int unsigned BW = 8;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RD_LEN   = 4'd1;
    localparam logic [3:0] ST_WR_LEN   = 4'd2;
    localparam logic [3:0] ST_I_ADDR   = 4'd3;
    localparam logic [3:0] ST_I_DATA   = 4'd4;
    localparam logic [3:0] ST_J_ADDR   = 4'd5;
    localparam logic [3:0] ST_J_DATA   = 4'd6;
    localparam logic [3:0] ST_WR_J     = 4'd7;
    localparam logic [3:0] ST_WR_I     = 4'd8;
    localparam logic [3:0] ST_PAD_ADDR = 4'd9;
    localparam logic [3:0] ST_WR_CT    = 4'd10;

    logic [3:0]    state, state_nxt;
    logic [BW-1:0] i, i_nxt, j, j_nxt, k, k_nxt, len, len_nxt;
    logic [BW-1:0] si, si_nxt, sj, sj_nxt, ptb, ptb_nxt;
    logic          dropping;

`ifdef PRGA_ENC_DROP_EN
    logic       dropping_nxt;
    logic [9:0] dcnt, dcnt_nxt;

    // Discard-phase bookkeeping: iteration counter and phase flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropping <= 1'b0;
            dcnt     <= '0;
        end else begin
            dropping <= dropping_nxt;
            dcnt     <= dcnt_nxt;
        end
    end
`else
    assign dropping = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
            ptb   <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            len   <= len_nxt;
            si    <= si_nxt;
            sj    <= sj_nxt;
            ptb   <= ptb_nxt;
        end
    end

    // Next-state, datapath updates and decoded memory-port outputs.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        k_nxt     = k;
        len_nxt   = len;
        si_nxt    = si;
        sj_nxt    = sj;
        ptb_nxt   = ptb;
`ifdef PRGA_ENC_DROP_EN
        dropping_nxt = dropping;
        dcnt_nxt     = dcnt;
`endif
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;

        case (state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    state_nxt = ST_RD_LEN;
                end
            end
            ST_RD_LEN: begin
                pt_addr   = '0;
                state_nxt = ST_WR_LEN;
            end
            ST_WR_LEN: begin
                ct_addr   = '0;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                len_nxt   = pt_rddata;
                if (pt_rddata == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    k_nxt     = 8'd1;
                    i_nxt     = 8'd1;
                    state_nxt = ST_I_ADDR;
`ifdef PRGA_ENC_DROP_EN
                    dropping_nxt = 1'b1;
                    dcnt_nxt     = '0;
`endif
                end
            end
            ST_I_ADDR: begin
                s_addr    = i;
                pt_addr   = dropping ? 8'd0 : k;
                state_nxt = ST_I_DATA;
            end
            ST_I_DATA: begin
                si_nxt = s_rddata;
                j_nxt  = j + s_rddata;
                if (!dropping) begin
                    ptb_nxt = pt_rddata;
                end
                state_nxt = ST_J_ADDR;
            end
            ST_J_ADDR: begin
                s_addr    = j;
                state_nxt = ST_J_DATA;
            end
            ST_J_DATA: begin
                sj_nxt    = s_rddata;
                state_nxt = ST_WR_J;
            end
            ST_WR_J: begin
                s_addr    = j;
                s_wrdata  = si;
                s_wren    = 1'b1;
                state_nxt = ST_WR_I;
            end
            ST_WR_I: begin
                s_addr    = i;
                s_wrdata  = sj;
                s_wren    = 1'b1;
                state_nxt = ST_PAD_ADDR;
`ifdef PRGA_ENC_DROP_EN
                // Discarded iterations skip the pad fetch and CT write.
                if (dropping) begin
                    i_nxt     = i + 8'd1;
                    dcnt_nxt  = dcnt + 10'd1;
                    state_nxt = ST_I_ADDR;
                    if (dcnt == 10'(DROP_N - 1)) begin
                        dropping_nxt = 1'b0;
                    end
                end
`endif
            end
            ST_PAD_ADDR: begin
                s_addr    = si + sj;
                state_nxt = ST_WR_CT;
            end
            ST_WR_CT: begin
                ct_addr   = k;
                ct_wrdata = s_rddata ^ ptb;
                ct_wren   = 1'b1;
                if (k == len) begin
                    state_nxt = ST_IDLE;
                end else begin
                    k_nxt     = k + 8'd1;
                    i_nxt     = i + 8'd1;
                    state_nxt = ST_I_ADDR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga_enc.sv
// Directed self-checking bench for prga_enc with behavioural S/PT/CT RAMs and an RC4 reference model.
`timescale 1ns/1ps
module tb_prga_enc;

`ifdef PRGA_ENC_DROP_EN
    localparam int DROP = 256;
`else
    localparam int DROP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic       s_wren, ct_wren;

    prga_enc dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [1:0] ld_sel = 2'd0;
    logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
    logic       mon_clr = 1'b0;
    int         s_wr_cnt, ct_wr_cnt, dual_cnt, ct_hi;

    // Synchronous RAMs, preload port and write monitors.
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
        end
        if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            ct_wr_cnt <= ct_wr_cnt + 1;
            if (int'(ct_addr) > ct_hi) ct_hi <= int'(ct_addr);
        end
        if (s_wren && ct_wren) dual_cnt <= dual_cnt + 1;
        case (ld_sel)
            2'd1: s_mem[ld_addr] <= ld_data;
            2'd2: pt_mem[ld_addr] <= ld_data;
            2'd3: ct_mem[ld_addr] <= ld_data;
            default: ;
        endcase
        if (mon_clr) begin
            s_wr_cnt  <= 0;
            ct_wr_cnt <= 0;
            dual_cnt  <= 0;
            ct_hi     <= -1;
        end
    end

    int         checks = 0;
    int         passes = 0;
    logic [7:0] key_b [16];
    logic [7:0] init_s [256];
    logic [7:0] work_s [256];
    logic [7:0] pt_buf [256];
    logic [7:0] m_ct [256];
    logic [7:0] exp_ct [256];
    logic [42:0] outs;
    assign outs = {rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren};

    function automatic int lat(input int l);
        return (l == 0) ? 2 : 2 + 6 * DROP + 8 * l;
    endfunction

    task automatic ksa(input int klen);
        logic [7:0] jj, t;
        for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
        jj = 8'd0;
        for (int a = 0; a < 256; a++) begin
            jj = jj + init_s[a] + key_b[a % klen];
            t = init_s[a]; init_s[a] = init_s[jj]; init_s[jj] = t;
        end
    endtask

    task automatic model_run(input int l);
        logic [7:0] mi, mj, t;
        for (int a = 0; a < 256; a++) work_s[a] = init_s[a];
        mi = 8'd0; mj = 8'd0;
        for (int n = 0; n < DROP; n++) begin
            mi = mi + 8'd1; mj = mj + work_s[mi];
            t = work_s[mi]; work_s[mi] = work_s[mj]; work_s[mj] = t;
        end
        m_ct[0] = 8'(l);
        for (int kk = 1; kk <= l; kk++) begin
            mi = mi + 8'd1; mj = mj + work_s[mi];
            t = work_s[mi]; work_s[mi] = work_s[mj]; work_s[mj] = t;
            m_ct[kk] = pt_buf[kk] ^ work_s[8'(work_s[mi] + work_s[mj])];
        end
    endtask

    task automatic load_byte(input logic [1:0] sel, input int a, input logic [7:0] d);
        @(negedge clk);
        ld_sel = sel; ld_addr = 8'(a); ld_data = d;
    endtask

    task automatic load_done;
        @(negedge clk);
        ld_sel = 2'd0;
    endtask

    task automatic load_s;
        for (int a = 0; a < 256; a++) load_byte(2'd1, a, init_s[a]);
        load_done();
    endtask

    task automatic load_pt(input int l);
        for (int a = 0; a <= l; a++) load_byte(2'd2, a, pt_buf[a]);
        load_done();
    endtask

    task automatic fill_ct(input int l);
        for (int a = 0; a <= l; a++) load_byte(2'd3, a, 8'hEE);
        load_done();
    endtask

    task automatic clr_mon;
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic start_job;
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 8000) begin
            @(posedge clk); #1; cyc++;
            if (rdy) return;
        end
    endtask

    task automatic setup_key_plaintext;
        logic [79:0] pv, hv;
        pv = 80'h09506C61696E74657874;
        hv = 80'h09BBF316E8D940AF0AD3;
        key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;
        ksa(3);
        for (int a = 0; a < 10; a++) begin
            pt_buf[a] = pv[8*(9-a) +: 8];
            exp_ct[a] = hv[8*(9-a) +: 8];
        end
        model_run(9);
`ifdef PRGA_ENC_DROP_EN
        for (int a = 0; a < 10; a++) exp_ct[a] = m_ct[a];
`endif
        load_s(); load_pt(9); fill_ct(9);
    endtask

    task automatic test_reset;
        logic [42:0] exp_idle;
        exp_idle = {1'b1, 42'd0};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== exp_idle) $display("FAIL reset_outs: got %h want %h", outs, exp_idle); else passes++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== exp_idle) $display("FAIL idle_outs: got %h want %h", outs, exp_idle); else passes++;
    endtask

    task automatic test_key_plaintext;
        int cyc;
        setup_key_plaintext();
        clr_mon();
        start_job();
        checks++;
        if (rdy !== 1'b0) $display("FAIL kp_rdy_fall: got %b want 0", rdy); else passes++;
        wait_done(cyc);
        checks++;
        if (cyc != lat(9)) $display("FAIL kp_latency: got %0d want %0d", cyc, lat(9)); else passes++;
        for (int a = 0; a < 10; a++) begin
            checks++;
            if (ct_mem[a] !== exp_ct[a]) $display("FAIL kp_ct[%0d]: got %h want %h", a, ct_mem[a], exp_ct[a]);
            else passes++;
        end
        checks++;
        if (s_wr_cnt != 2 * (9 + DROP)) $display("FAIL kp_s_writes: got %0d want %0d", s_wr_cnt, 2 * (9 + DROP));
        else passes++;
        checks++;
        if (dual_cnt != 0 || ct_wr_cnt != 10) $display("FAIL kp_strobes: dual %0d ct %0d want 0 10", dual_cnt, ct_wr_cnt);
        else passes++;
    endtask

    task automatic test_wiki;
        int cyc, bad;
        logic [47:0] pv, hv;
        pv = 48'h057065646961;
        hv = 48'h051021BF0420;
        key_b[0] = 8'h57; key_b[1] = 8'h69; key_b[2] = 8'h6B; key_b[3] = 8'h69;
        ksa(4);
        for (int a = 0; a < 6; a++) begin
            pt_buf[a] = pv[8*(5-a) +: 8];
            exp_ct[a] = hv[8*(5-a) +: 8];
        end
        model_run(5);
`ifdef PRGA_ENC_DROP_EN
        for (int a = 0; a < 6; a++) exp_ct[a] = m_ct[a];
`endif
        load_s(); load_pt(5); fill_ct(5);
        start_job();
        wait_done(cyc);
        checks++;
        if (cyc != lat(5)) $display("FAIL wiki_latency: got %0d want %0d", cyc, lat(5)); else passes++;
        for (int a = 0; a < 6; a++) begin
            checks++;
            if (ct_mem[a] !== exp_ct[a]) $display("FAIL wiki_ct[%0d]: got %h want %h", a, ct_mem[a], exp_ct[a]);
            else passes++;
        end
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== work_s[a]) bad++;
        checks++;
        if (bad != 0) $display("FAIL wiki_final_s: got %0d differing bytes want 0", bad); else passes++;
    endtask

    task automatic test_len_zero;
        int cyc;
        pt_buf[0] = 8'h00;
        load_pt(0); fill_ct(0);
        clr_mon();
        start_job();
        checks++;
        if (rdy !== 1'b0) $display("FAIL l0_rdy_fall: got %b want 0", rdy); else passes++;
        wait_done(cyc);
        checks++;
        if (cyc != 2) $display("FAIL l0_latency: got %0d want 2", cyc); else passes++;
        checks++;
        if (ct_mem[0] !== 8'h00) $display("FAIL l0_ct0: got %h want 00", ct_mem[0]); else passes++;
        checks++;
        if (s_wr_cnt != 0 || ct_wr_cnt != 1) $display("FAIL l0_writes: s %0d ct %0d want 0 1", s_wr_cnt, ct_wr_cnt);
        else passes++;
    endtask

    task automatic test_busy_en;
        int cyc;
        setup_key_plaintext();
        clr_mon();
        start_job();
        cyc = 0;
        while (cyc < 8000) begin
            @(posedge clk); #1; cyc++;
            if (rdy) break;
            en = (cyc == 1 || cyc == 5 || cyc == 20 || cyc == 40) ? 1'b1 : 1'b0;
        end
        en = 1'b0;
        checks++;
        if (cyc != lat(9)) $display("FAIL busy_latency: got %0d want %0d", cyc, lat(9)); else passes++;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rdy !== 1'b1 || ct_wr_cnt != 10) $display("FAIL busy_no_queue: rdy %b ct %0d want 1 10", rdy, ct_wr_cnt);
        else passes++;
        checks++;
        if (ct_mem[0] !== 8'h09 || ct_mem[9] !== exp_ct[9])
            $display("FAIL busy_ct: got %h %h want 09 %h", ct_mem[0], ct_mem[9], exp_ct[9]);
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] seq;
        pt_buf[0] = 8'h00;
        load_pt(0);
        clr_mon();
        @(negedge clk); en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            seq[5-n] = rdy;
            if (n == 3) en = 1'b0;
        end
        checks++;
        if (seq !== 6'b001001) $display("FAIL b2b_rdy_seq: got %b want 001001", seq); else passes++;
        checks++;
        if (ct_wr_cnt != 2) $display("FAIL b2b_jobs: got %0d ct writes want 2", ct_wr_cnt); else passes++;
    endtask

    task automatic test_reset_midjob;
        int cyc, bad;
        logic [42:0] exp_idle;
        exp_idle = {1'b1, 42'd0};
        setup_key_plaintext();
        clr_mon();
        start_job();
        repeat (2 + 6 * DROP + 16 + 3) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== exp_idle) $display("FAIL mid_reset_outs: got %h want %h", outs, exp_idle); else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ct_wr_cnt != 3 || ct_hi != 2) $display("FAIL mid_ct_writes: cnt %0d hi %0d want 3 2", ct_wr_cnt, ct_hi);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ct_wr_cnt != 3 || ct_mem[3] !== 8'hEE) $display("FAIL mid_no_strobes: cnt %0d ct3 %h want 3 ee", ct_wr_cnt, ct_mem[3]);
        else passes++;
        load_s(); fill_ct(9);
        start_job();
        wait_done(cyc);
        bad = 0;
        for (int a = 0; a < 10; a++) if (ct_mem[a] !== exp_ct[a]) bad++;
        checks++;
        if (bad != 0 || cyc != lat(9)) $display("FAIL mid_rerun: bad %0d cyc %0d want 0 %0d", bad, cyc, lat(9));
        else passes++;
    endtask

`ifdef PRGA_ENC_DROP_EN
    task automatic test_drop_long;
        int cyc, bad;
        logic [7:0] orig [256];
        key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;
        ksa(3);
        pt_buf[0] = 8'd255;
        for (int a = 1; a < 256; a++) pt_buf[a] = 8'(a * 7 + 3);
        for (int a = 0; a < 256; a++) orig[a] = pt_buf[a];
        model_run(255);
        load_s(); load_pt(255);
        start_job();
        wait_done(cyc);
        checks++;
        if (cyc != 2 + 1536 + 2040) $display("FAIL drop_latency: got %0d want %0d", cyc, 2 + 1536 + 2040); else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (ct_mem[a] !== m_ct[a]) bad++;
        checks++;
        if (bad != 0) $display("FAIL drop_ct: got %0d differing bytes want 0", bad); else passes++;
        for (int a = 0; a < 256; a++) pt_buf[a] = ct_mem[a];
        load_s(); load_pt(255);
        start_job();
        wait_done(cyc);
        bad = 0;
        for (int a = 0; a < 256; a++) if (ct_mem[a] !== orig[a]) bad++;
        checks++;
        if (bad != 0) $display("FAIL drop_roundtrip: got %0d differing bytes want 0", bad); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_key_plaintext();
        test_wiki();
        test_len_zero();
        test_busy_en();
        test_back_to_back();
        test_reset_midjob();
`ifdef PRGA_ENC_DROP_EN
        test_drop_long();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prga_enc.md
# prga_enc

ARC4 encryption engine: consumes a length-prefixed plaintext message from the PT memory, runs the RC4 pseudo-random generation over an already-initialised S memory, and writes a length-prefixed ciphertext message to the CT memory. It is the transmit-side counterpart of the existing PRGA decryptor and sits after the KSA stage. It shares the same S, PT and CT on-chip RAM style and the same en/rdy handshake.

## Interface
- DROP_N, 256: number of keystream bytes discarded before encryption; used only when PRGA_ENC_DROP_EN is defined. Range 1..1023.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  engine idle and able to accept en.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data; valid one cycle after the address is driven.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write strobe.
- pt_addr  out  8  PT memory address.
- pt_rddata  in  8  PT read data; one-cycle read latency.
- ct_addr  out  8  CT memory address.
- ct_wrdata  out  8  CT write data.
- ct_wren  out  1  CT write strobe.

## Operation
- Message format: byte 0 is length L (0..255); bytes 1..L are the payload. CT receives the same layout: ct[0]=L, ct[k]=pt[k]^pad_k.
- Indices i, j and the byte counter k are 8-bit and wrap mod 256. pad address = (si+sj) mod 256. i and j clear to 0 at each job start.
- All outputs are combinational from state and registers. Every address, write-data and wren output is 0 in any state that does not drive it.
- IDLE: rdy=1. en=1 → RD_LEN, rdy=0.
- RD_LEN: pt_addr=0.
- WR_LEN: ct_addr=0, ct_wrdata=pt_rddata, ct_wren=1; latch L.
  - L=0 → IDLE.
  - Otherwise set k=1, i=1 → I_ADDR (or DROP phase if configured).
- I_ADDR: s_addr=i, pt_addr=k.
- I_DATA: si←s_rddata, ptb←pt_rddata, j←j+s_rddata.
- J_ADDR: s_addr=j.
- J_DATA: sj←s_rddata.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- PAD_ADDR: s_addr=si+sj.
- WR_CT: ct_addr=k, ct_wrdata=s_rddata^ptb, ct_wren=1.
  - k=L → IDLE with rdy=1.
  - Otherwise k←k+1, i←i+1 → I_ADDR.
- At most one write strobe is high in any cycle. S and PT are never written by this block.

## Timing
- Reset value of every output: rdy=1; all addresses, write data and wren = 0. Internal i, j, k, L, si, sj and ptb reset to 0. State resets to IDLE.
- rdy falls on the edge that samples en=1. en held high after completion starts a new job on the edge after rdy rises.
- en while rdy=0 is ignored; there is no queueing.
- Per-byte cost: 8 cycles. Job latency from the accepting edge to rdy=1: 2+8·L cycles (L=0: 2 cycles).
- Reset mid-job: immediate return to IDLE with rdy=1. Writes already performed stay in memory. No further strobes are issued.
- L=255: k reaches 255 and terminates on k=L. There is no overflow to 0.
- i wraps 255→0 naturally on messages of 255 bytes with the drop phase enabled.

## Configuration
- PRGA_ENC_DROP_EN defined: after WR_LEN with L≠0, run DROP_N keystream iterations. Each iteration is the I_ADDR, I_DATA, J_ADDR, J_DATA, WR_J, WR_I sequence with no pt or ct access, costing 6 cycles. Then encryption proceeds with i incremented as normal. Latency becomes 2+6·DROP_N+8·L. L=0 skips the drop phase.
- Not defined: no drop phase. DROP_N is ignored and the block is plain RC4.

## Test plan
- Reset, then idle: rdy=1 and all strobes 0. en pulses while busy leave the job length unchanged.
- S preloaded with KSA("Key"=0x4B6579), pt = 09,"Plaintext" → ct = 09,BB,F3,16,E8,D9,40,AF,0A,D3. rdy returns after 74 cycles.
- S preloaded with KSA("Wiki"), pt = 05,"pedia" → ct = 05,10,21,BF,04,20. The final S matches the reference model.
- L=0 → ct[0]=00, no S writes, rdy high 2 cycles after acceptance.
- Assert rst_n low during byte 3 of a 9-byte job → rdy=1 next cycle, no ct writes to addresses ≥3. A subsequent full job on reinitialised S gives correct ct.
- PRGA_ENC_DROP_EN with DROP_N=256 and a 255-byte message → ct matches the RC4-drop[256] model and latency is 2+1536+2040 cycles. Round trip through the decryptor on the same initial S recovers pt.
